xpackvec: RTL and testbench



---
 rtl/xpackvec.sv | 122 ++++++++++++
 tb/tb_xpackvec.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/xpackvec.sv
// xpackvec: serial-to-parallel lane packer.
// Collects NEl valid-strobed samples into one wide vector. It presents the
// vector together with a constant lane-index vector and a one-cycle o_nd
// strobe. A start-of-frame re-aligns the packer. If that cuts a partial
// vector short, o_err pulses for one cycle.
module xpackvec #(
  parameter  int NEl  = 8,
  parameter  int BWID = 16,
  localparam int IWID = $clog2(NEl) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BWID-1:0]     i_data,
  input  logic                i_nd,
  input  logic                i_sof,
  output logic [BWID*NEl-1:0] ov_data,
  output logic [IWID*NEl-1:0] ov_index,
  output logic                o_nd,
  output logic                o_err,
  output logic [IWID-1:0]     o_cnt
);

  localparam logic [IWID-1:0] LAST_LANE = IWID'(NEl - 1);

  // Fill counter and registered outputs.
  logic [IWID-1:0]     cnt_reg, cnt_next;
  logic [BWID*NEl-1:0] data_reg, data_next;
  logic [IWID*NEl-1:0] index_reg, index_next;
  logic                nd_reg, nd_next;
  logic                err_reg, err_next;

  // Shadow lanes 0..NEl-2 as seen by the output mux. The final lane never
  // needs storage because the completing sample goes straight to the output.
  logic [BWID-1:0]     shadow_lane [NEl-1];
  logic [BWID*NEl-1:0] complete_vec;
  logic [IWID*NEl-1:0] index_const;

  // Beat classification: sof always wins over a completing beat.
  logic beat_sof, beat_last, beat_fill;
  assign beat_sof  = i_nd && i_sof;
  assign beat_last = i_nd && !i_sof && (cnt_reg == LAST_LANE);
  assign beat_fill = i_nd && !i_sof && (cnt_reg != LAST_LANE);

  genvar gi;
  generate
    for (gi = 0; gi < NEl - 1; gi++) begin : gen_lane
      localparam logic IS_LANE0 = (gi == 0);
      logic [BWID-1:0] lane_reg;
      logic            lane_we;

      // A sof beat always lands in lane 0; ordinary beats land in lane cnt.
      assign lane_we = beat_sof ? IS_LANE0
                                : (beat_fill && (cnt_reg == IWID'(gi)));

      // Shadow lane storage, separate from the held output vector.
      always_ff @(posedge clk) begin
        if (rst) begin
          lane_reg <= '0;
        end else if (lane_we) begin
          lane_reg <= i_data;
        end
      end

      assign shadow_lane[gi] = lane_reg;
      assign complete_vec[BWID*gi +: BWID] = lane_reg;
    end

    for (gi = 0; gi < NEl; gi++) begin : gen_index
      assign index_const[IWID*gi +: IWID] = IWID'(gi);
    end
  endgenerate

  // The completing sample fills the top lane directly.
  assign complete_vec[BWID*(NEl-1) +: BWID] = i_data;

  // Next-state selection for the counter, the strobes and the held outputs.
  always_comb begin
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    index_next = index_reg;
    nd_next    = 1'b0;
    err_next   = 1'b0;
    if (beat_sof) begin
      cnt_next = IWID'(1);
      err_next = (cnt_reg != '0);
    end else if (beat_last) begin
      cnt_next   = '0;
      data_next  = complete_vec;
      index_next = index_const;
      nd_next    = 1'b1;
    end else if (beat_fill) begin
      cnt_next = cnt_reg + IWID'(1);
    end else if (i_sof) begin
      cnt_next = '0;
      err_next = (cnt_reg != '0);
    end
  end

  // State register; reset drops any partial vector silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      data_reg  <= '0;
      index_reg <= '0;
      nd_reg    <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      index_reg <= index_next;
      nd_reg    <= nd_next;
      err_reg   <= err_next;
    end
  end

  assign ov_data  = data_reg;
  assign ov_index = index_reg;
  assign o_nd     = nd_reg;
  assign o_err    = err_reg;
  assign o_cnt    = cnt_reg;

endmodule

// File: tb/tb_xpackvec.sv
// Testbench for xpackvec: directed scenarios plus random traffic checked
// against a queue-based frame model.
module tb_xpackvec;

  localparam int NEL  = 8;
  localparam int BWID = 16;
  localparam int IWID = $clog2(NEL) + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [BWID-1:0]     i_data;
  logic                i_nd;
  logic                i_sof;
  logic [BWID*NEL-1:0] ov_data;
  logic [IWID*NEL-1:0] ov_index;
  logic                o_nd;
  logic                o_err;
  logic [IWID-1:0]     o_cnt;

  xpackvec #(.NEl(NEL), .BWID(BWID)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_data   (i_data),
    .i_nd     (i_nd),
    .i_sof    (i_sof),
    .ov_data  (ov_data),
    .ov_index (ov_index),
    .o_nd     (o_nd),
    .o_err    (o_err),
    .o_cnt    (o_cnt)
  );

  always #5 clk = ~clk;

  // Reference model state: samples of the current partial frame.
  logic [BWID-1:0]     frame_q [$];
  logic [BWID*NEL-1:0] exp_data;
  logic [IWID*NEL-1:0] exp_index;
  logic                exp_nd;
  logic                exp_err;
  logic [IWID-1:0]     exp_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  int n_out  = 0;

  logic [BWID*NEL-1:0] const_vec;

  // Apply one cycle of stimulus, advance the model, then check every output.
  task automatic step(input logic r, input logic nd, input logic sof,
                      input logic [BWID-1:0] d);
    rst    = r;
    i_nd   = nd;
    i_sof  = sof;
    i_data = d;
    @(posedge clk);
    exp_nd  = 1'b0;
    exp_err = 1'b0;
    if (r) begin
      frame_q.delete();
      exp_data  = '0;
      exp_index = '0;
    end else if (nd) begin
      if (sof) begin
        exp_err = (frame_q.size() != 0);
        frame_q.delete();
      end
      frame_q.push_back(d);
      if (frame_q.size() == NEL) begin
        for (int k = 0; k < NEL; k++) begin
          exp_data[BWID*k +: BWID]  = frame_q[k];
          exp_index[IWID*k +: IWID] = IWID'(k);
        end
        exp_nd = 1'b1;
        frame_q.delete();
      end
    end else if (sof) begin
      exp_err = (frame_q.size() != 0);
      frame_q.delete();
    end
    exp_cnt = IWID'(frame_q.size());
    @(negedge clk);
    n_vec++;
    assert (o_nd === exp_nd) else begin
      n_miss++; $error("FAIL o_nd observed=%0b expected=%0b", o_nd, exp_nd);
    end
    n_vec++;
    assert (o_err === exp_err) else begin
      n_miss++; $error("FAIL o_err observed=%0b expected=%0b", o_err, exp_err);
    end
    n_vec++;
    assert (o_cnt === exp_cnt) else begin
      n_miss++; $error("FAIL o_cnt observed=%0d expected=%0d", o_cnt, exp_cnt);
    end
    n_vec++;
    assert (ov_data === exp_data) else begin
      n_miss++; $error("FAIL ov_data observed=%h expected=%h", ov_data, exp_data);
    end
    n_vec++;
    assert (ov_index === exp_index) else begin
      n_miss++; $error("FAIL ov_index observed=%h expected=%h", ov_index, exp_index);
    end
    if (o_nd === 1'b1) begin
      n_out++;
      $display("vector %0d: data=%h index=%h", n_out, ov_data, ov_index);
    end
  endtask

  initial begin
    rst = 1'b1; i_nd = 1'b0; i_sof = 1'b0; i_data = '0;
    exp_data = '0; exp_index = '0;
    for (int k = 0; k < NEL; k++) const_vec[BWID*k +: BWID] = BWID'(k + 1);

    // Reset state.
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);

    // Samples 1..8 at full rate.
    for (int s = 1; s <= NEL; s++) step(1'b0, 1'b1, 1'b0, BWID'(s));
    n_vec++;
    assert (ov_data === const_vec) else begin
      n_miss++; $error("FAIL seq_full observed=%h expected=%h", ov_data, const_vec);
    end

    // Same samples with random gaps of 0-5 cycles.
    for (int s = 1; s <= NEL; s++) begin
      repeat ($urandom_range(0, 5)) step(1'b0, 1'b0, 1'b0, BWID'($urandom));
      step(1'b0, 1'b1, 1'b0, BWID'(s));
    end
    n_vec++;
    assert (ov_data === const_vec) else begin
      n_miss++; $error("FAIL seq_gaps observed=%h expected=%h", ov_data, const_vec);
    end

    // Three samples, sof with 0xAAAA, then seven more.
    for (int s = 0; s < 3; s++) step(1'b0, 1'b1, 1'b0, BWID'(16'h5500 + s));
    step(1'b0, 1'b1, 1'b1, 16'hAAAA);
    for (int s = 0; s < NEL - 1; s++) step(1'b0, 1'b1, 1'b0, BWID'(16'h3300 + s));
    n_vec++;
    assert (ov_data[BWID-1:0] === 16'hAAAA) else begin
      n_miss++; $error("FAIL sof_lane0 observed=%h expected=aaaa", ov_data[BWID-1:0]);
    end

    // 24 samples back-to-back.
    for (int s = 0; s < 3 * NEL; s++) step(1'b0, 1'b1, 1'b0, BWID'($urandom));

    // sof on the 8th beat.
    for (int s = 0; s < NEL - 1; s++) step(1'b0, 1'b1, 1'b0, BWID'($urandom));
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    n_vec++;
    assert (o_err === 1'b1 && o_nd === 1'b0 && o_cnt === IWID'(1)) else begin
      n_miss++; $error("FAIL sof_last observed=err%0b nd%0b cnt%0d expected=err1 nd0 cnt1",
                       o_err, o_nd, o_cnt);
    end
    for (int s = 0; s < NEL - 1; s++) step(1'b0, 1'b1, 1'b0, BWID'($urandom));

    // sof without data on a partial, then on an empty packer.
    for (int s = 0; s < 4; s++) step(1'b0, 1'b1, 1'b0, BWID'($urandom));
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b1, '0);

    // Reset mid-fill at count 5.
    for (int s = 0; s < 5; s++) step(1'b0, 1'b1, 1'b0, BWID'($urandom));
    step(1'b1, 1'b0, 1'b0, '0);
    n_vec++;
    assert (o_cnt === '0 && o_err === 1'b0 && ov_data === '0) else begin
      n_miss++; $error("FAIL rst_mid observed=cnt%0d err%0b data%h expected=cnt0 err0 data0",
                       o_cnt, o_err, ov_data);
    end

    // Random traffic.
    for (int t = 0; t < 600; t++) begin
      step(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
           BWID'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
